// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and constants for the FIFO write arbiter
// Purpose: FSM state encoding, requester count, default burst length and
//          small index/one-hot helpers used by the arbiter files.
// Ports:   none (package).
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int NUM_REQ           = 4;
  localparam int IDX_W             = 2;
  localparam int DEFAULT_BURST_LEN = 4;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Grants are one-hot by construction, so a plain OR-encode is enough.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO bus bundle for the write arbiter
// Purpose: groups the requester side (req, wr_data, gnt, ack) and the FIFO
//          side (FULL, w_en, WR) into one bundle.
// Ports:   master - arbiter view (drives gnt, ack, w_en, WR)
//          slave  - environment view (drives req, wr_data, FULL)
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int MEMORY_WIDTH = 4
);

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MEMORY_WIDTH-1:0] wr_data;
  logic                            FULL;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              ack;
  logic                            w_en;
  logic [MEMORY_WIDTH-1:0]         WR;

  modport master (
    input  req, wr_data, FULL,
    output gnt, ack, w_en, WR
  );

  modport slave (
    output req, wr_data, FULL,
    input  gnt, ack, w_en, WR
  );

endinterface

// File: rtl/d_ff_async_en.sv
// rtl/d_ff_async_en.sv - asynchronous-reset register with load enable
// Purpose: generic WIDTH-bit flop, async active-high reset to RST_VAL.
// Ports:   clk, rst (async, active-high), en (load), d (next), q (state)
module d_ff_async_en #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - round-robin winner search
// Purpose: finds the first set req bit searching upward from last+1, wrapping
//          modulo 4; last itself has the lowest priority.
// Ports:   req[3:0] requests, last[1:0] previous grant,
//          valid any request present, idx[1:0] winning index
module rr_pick
  import fifo_wr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    valid = |req;
    idx   = last;
    cand  = last;
    // Walk from farthest (last+4 == last) to nearest (last+1); the nearest
    // set candidate is written last and therefore wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - 4-way round-robin burst arbiter into a shared FIFO
// Purpose: grants one requester at a time for up to BURST_LEN writes, stalls
//          on FULL without losing the grant, always re-arbitrates via IDLE.
// Ports:   clk, rst (async, active-high),
//          bus (master): req, wr_data, FULL in; gnt (registered), ack, w_en, WR out
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int MEMORY_WIDTH = 4,
  parameter int BURST_LEN    = DEFAULT_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);

  localparam logic [3:0] CNT_LAST = 4'(BURST_LEN - 1);

  logic               state_q;
  state_t             state;
  state_t             state_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   last_q;
  logic [3:0]         cnt_q;
  logic [3:0]         cnt_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   g;
  logic               in_burst;
  logic               req_g;
  logic               w_en;
  logic               start;
  logic               burst_done;

  assign state = state_t'(state_q);

  rr_pick u_rr_pick (
    .req   (bus.req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign g        = onehot_to_idx(gnt_q);
  assign in_burst = (state == BURST);
  assign req_g    = bus.req[g];

  // Writes never happen while FULL or during reset; rst also clears state
  // asynchronously, the explicit term just keeps the outputs quiet in that cycle.
  assign w_en = in_burst & req_g & ~bus.FULL & ~rst;

  assign start      = (state == IDLE) & pick_valid;
  assign burst_done = in_burst & (~req_g | (w_en & (cnt_q == CNT_LAST)));

  assign state_d = start ? BURST : IDLE;
  assign gnt_d   = start ? idx_to_onehot(pick_idx) : '0;
  assign cnt_d   = start ? 4'd0 : cnt_q + 4'd1;

  // state and gnt change together: on a new grant or on burst exit.
  d_ff_async_en #(.WIDTH(1), .RST_VAL(1'b0)) u_state_ff (
    .clk (clk),
    .rst (rst),
    .en  (start | burst_done),
    .d   (state_d),
    .q   (state_q)
  );

  d_ff_async_en #(.WIDTH(NUM_REQ), .RST_VAL('0)) u_gnt_ff (
    .clk (clk),
    .rst (rst),
    .en  (start | burst_done),
    .d   (gnt_d),
    .q   (gnt_q)
  );

  // last resets to 3 so requester 0 is searched first after reset.
  d_ff_async_en #(.WIDTH(IDX_W), .RST_VAL(2'd3)) u_last_ff (
    .clk (clk),
    .rst (rst),
    .en  (burst_done),
    .d   (g),
    .q   (last_q)
  );

  // Cleared on burst entry, counts accepted writes, holds while stalled.
  d_ff_async_en #(.WIDTH(4), .RST_VAL(4'd0)) u_cnt_ff (
    .clk (clk),
    .rst (rst),
    .en  (start | w_en),
    .d   (cnt_d),
    .q   (cnt_q)
  );

  assign bus.gnt  = gnt_q;
  assign bus.w_en = w_en;
  assign bus.ack  = w_en ? gnt_q : '0;
  assign bus.WR   = ((gnt_q != '0) && !rst) ? bus.wr_data[g*MEMORY_WIDTH +: MEMORY_WIDTH]
                                            : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int MW = 8;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [3:0]    ack;
    logic          w_en;
    logic [MW-1:0] wr;
  } obs_t;

  typedef struct packed {
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       w_en;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.MEMORY_WIDTH(MW)) if4 ();
  fifo_wr_arbiter_if #(.MEMORY_WIDTH(MW)) if2 ();

  fifo_wr_arbiter #(.MEMORY_WIDTH(MW), .BURST_LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  fifo_wr_arbiter #(.MEMORY_WIDTH(MW), .BURST_LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = BURST_LEN 4 instance, 1 = BURST_LEN 2 instance.
  bit   m_busy[2];
  int   m_g[2];
  int   m_last[2];
  int   m_cnt[2];
  int   m_bl[2];
  obs_t sb_q0[$];
  obs_t sb_q1[$];
  obs_t s_obs[2];

  bit         prop_on = 1'b0;
  int         run_len[2];
  logic [3:0] prev_gnt[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_busy[d] = 1'b0;
    m_g[d]    = 0;
    m_cnt[d]  = 0;
    m_last[d] = 3;
  endtask

  function automatic obs_t predict(input int d, input logic [3:0] r, input logic f,
                                   input logic rs, input logic [4*MW-1:0] wd);
    obs_t o;
    o = '0;
    if (!rs && m_busy[d]) begin
      o.gnt  = 4'b0001 << m_g[d];
      o.w_en = r[m_g[d]] && !f;
      o.ack  = o.w_en ? o.gnt : 4'b0000;
      o.wr   = wd[m_g[d]*MW +: MW];
    end
    return o;
  endfunction

  task automatic model_clock(input int d, input logic [3:0] r, input logic f, input logic rs);
    bit w;
    if (rs) begin
      model_reset(d);
    end else if (!m_busy[d]) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_busy[d] && r[(m_last[d] + k) % 4]) begin
          m_busy[d] = 1'b1;
          m_g[d]    = (m_last[d] + k) % 4;
          m_cnt[d]  = 0;
        end
      end
    end else begin
      w = r[m_g[d]] && !f;
      if (!r[m_g[d]] || (w && m_cnt[d] == m_bl[d] - 1)) begin
        m_busy[d] = 1'b0;
        m_last[d] = m_g[d];
      end else if (w) begin
        m_cnt[d]++;
      end
    end
  endtask

  task automatic props(input int d, input logic f);
    obs_t o;
    o = s_obs[d];
    check("ack_onehot0", 64'($onehot0(o.ack)), 64'(1));
    check("wen_while_full", 64'(o.w_en & f), 64'(0));
    if (o.gnt != prev_gnt[d] || o.gnt == 4'b0000) run_len[d] = 0;
    if (o.w_en) run_len[d]++;
    check("burst_run_len", 64'(run_len[d] <= m_bl[d]), 64'(1));
    prev_gnt[d] = o.gnt;
  endtask

  // One clock: drive inputs, queue predictions, compare at negedge, advance model.
  task automatic step(input logic [3:0] r, input logic f, input logic rs);
    logic [4*MW-1:0] wd;
    obs_t            e;
    wd           = 32'($urandom);
    rst          = rs;
    if4.req      = r;
    if4.FULL     = f;
    if4.wr_data  = wd;
    if2.req      = r;
    if2.FULL     = f;
    if2.wr_data  = wd;
    if (rs) begin
      model_reset(0);
      model_reset(1);
    end
    sb_q0.push_back(predict(0, r, f, rs, wd));
    sb_q1.push_back(predict(1, r, f, rs, wd));
    @(negedge clk);
    s_obs[0].gnt  = if4.gnt;
    s_obs[0].ack  = if4.ack;
    s_obs[0].w_en = if4.w_en;
    s_obs[0].wr   = if4.WR;
    s_obs[1].gnt  = if2.gnt;
    s_obs[1].ack  = if2.ack;
    s_obs[1].w_en = if2.w_en;
    s_obs[1].wr   = if2.WR;
    e = sb_q0.pop_front();
    check("model_bl4", 64'(s_obs[0]), 64'(e));
    e = sb_q1.pop_front();
    check("model_bl2", 64'(s_obs[1]), 64'(e));
    if (prop_on) begin
      props(0, f);
      props(1, f);
    end
    @(posedge clk);
    model_clock(0, r, f, rs);
    model_clock(1, r, f, rs);
    #1;
  endtask

  task automatic wait_grant4(input logic [3:0] r, output int idx);
    idx = -1;
    for (int i = 0; i < 8 && idx < 0; i++) begin
      step(r, 1'b0, 1'b0);
      if (s_obs[0].gnt != 4'b0000) idx = oh_idx(s_obs[0].gnt);
    end
  endtask

  task automatic wait_idle4(input logic [3:0] r);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      step(r, 1'b0, 1'b0);
      if (s_obs[0].gnt == 4'b0000) done = 1'b1;
    end
    check("idle_within_budget", 64'(done), 64'(1));
  endtask

  vec_t tbl[8];
  int   gq[$];

  initial begin
    int         idx;
    int         writes;
    int         idle;
    int         exp_i;
    bit         seen;
    logic [3:0] prev;
    logic [3:0] g;
    logic [3:0] rr;
    logic       ff;

    m_bl[0] = 4;
    m_bl[1] = 2;
    model_reset(0);
    model_reset(1);
    if4.req = '0; if4.FULL = 1'b0; if4.wr_data = '0;
    if2.req = '0; if2.FULL = 1'b0; if2.wr_data = '0;
    @(posedge clk);
    #1;

    // Reset state: outputs quiet even with a request pending.
    step(4'b0001, 1'b0, 1'b1);
    check("reset_gnt", 64'(s_obs[0].gnt), 64'(0));
    check("reset_ack", 64'(s_obs[0].ack), 64'(0));
    check("reset_wen", 64'(s_obs[0].w_en), 64'(0));
    check("reset_wr", 64'(s_obs[0].wr), 64'(0));

    // Single requester, BURST_LEN 4: grant next cycle, 4 writes, IDLE.
    tbl[0] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[2] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[3] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[4] = '{4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1};
    tbl[5] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[6] = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[7] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].req, tbl[i].full, 1'b0);
      check($sformatf("vec%0d_gnt", i), 64'(s_obs[0].gnt), 64'(tbl[i].gnt));
      check($sformatf("vec%0d_ack", i), 64'(s_obs[0].ack), 64'(tbl[i].ack));
      check($sformatf("vec%0d_wen", i), 64'(s_obs[0].w_en), 64'(tbl[i].w_en));
      if (tbl[i].gnt == 4'b0000) check($sformatf("vec%0d_wr_zero", i), 64'(s_obs[0].wr), 64'(0));
    end

    // All requesting, BURST_LEN 2: order 0,1,2,3,0, two writes then one IDLE each.
    step(4'b0000, 1'b0, 1'b1);
    gq = '{0, 1, 2, 3, 0};
    writes = 0; idle = 0; seen = 1'b0; prev = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      g = s_obs[1].gnt;
      if (prev == 4'b0000 && g != 4'b0000) begin
        if (seen) check("rr_idle_gap", 64'(idle), 64'(1));
        exp_i = (gq.size() > 0) ? gq.pop_front() : -2;
        check("rr_order", 64'(oh_idx(g)), 64'(exp_i));
        seen   = 1'b1;
        writes = 0;
      end
      if (prev != 4'b0000 && g == 4'b0000) begin
        check("rr_writes_per_grant", 64'(writes), 64'(2));
        idle = 0;
      end
      if (g == 4'b0000) idle++;
      if (s_obs[1].w_en) writes++;
      prev = g;
    end
    check("rr_all_granted", 64'(gq.size()), 64'(0));

    // Requester 2 stalled by FULL mid-burst keeps its grant and finishes.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    wait_grant4(4'b0100, idx);
    check("stall_grant_idx", 64'(idx), 64'(2));
    step(4'b0100, 1'b0, 1'b0);
    check("stall_pre_write", 64'(s_obs[0].w_en), 64'(1));
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b1, 1'b0);
      check("stall_wen", 64'(s_obs[0].w_en), 64'(0));
      check("stall_gnt", 64'(s_obs[0].gnt), 64'(4'b0100));
    end
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      if (s_obs[0].gnt == 4'b0000) break;
      if (s_obs[0].w_en) writes++;
    end
    check("stall_remaining_writes", 64'(writes), 64'(2));
    check("stall_ends_idle", 64'(s_obs[0].gnt), 64'(0));

    // Requester 1 drops after one write; search then goes 2, 3, 0.
    step(4'b0000, 1'b0, 1'b0);
    wait_grant4(4'b0010, idx);
    check("drop_grant_idx", 64'(idx), 64'(1));
    check("drop_first_write", 64'(s_obs[0].w_en), 64'(1));
    step(4'b1101, 1'b0, 1'b0);
    check("drop_no_write", 64'(s_obs[0].w_en), 64'(0));
    check("drop_no_ack", 64'(s_obs[0].ack), 64'(0));
    step(4'b1101, 1'b0, 1'b0);
    check("drop_idle_gnt", 64'(s_obs[0].gnt), 64'(0));
    check("drop_last", 64'(dut4.last_q), 64'(1));
    wait_grant4(4'b1101, idx);
    check("drop_next_2", 64'(idx), 64'(2));
    wait_idle4(4'b1101);
    wait_grant4(4'b1101, idx);
    check("drop_next_3", 64'(idx), 64'(3));
    wait_idle4(4'b1101);
    wait_grant4(4'b1101, idx);
    check("drop_next_0", 64'(idx), 64'(0));

    // Reset mid-burst aborts; after release requester 0 outranks 3.
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    wait_grant4(4'b1000, idx);
    check("rst_pre_grant", 64'(idx), 64'(3));
    for (int i = 0; i < 2; i++) begin
      step(4'b1000, 1'b0, 1'b1);
      check("rst_mid_gnt", 64'(s_obs[0].gnt), 64'(0));
      check("rst_mid_wen", 64'(s_obs[0].w_en), 64'(0));
      check("rst_mid_wr", 64'(s_obs[0].wr), 64'(0));
    end
    step(4'b1000, 1'b0, 1'b0);
    check("rst_release_idle", 64'(s_obs[0].gnt), 64'(0));
    step(4'b1000, 1'b0, 1'b0);
    check("rst_release_gnt3", 64'(s_obs[0].gnt), 64'(4'b1000));
    step(4'b1000, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b0);
    check("rst2_release_idle", 64'(s_obs[0].gnt), 64'(0));
    step(4'b1001, 1'b0, 1'b0);
    check("rst2_release_gnt0", 64'(s_obs[0].gnt), 64'(4'b0001));

    // Random traffic with sticky requests so bursts reach their length limit.
    step(4'b0000, 1'b0, 1'b1);
    prop_on     = 1'b1;
    run_len[0]  = 0;
    run_len[1]  = 0;
    prev_gnt[0] = 4'b0000;
    prev_gnt[1] = 4'b0000;
    rr = 4'b0000;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      ff = ($urandom_range(0, 3) == 0);
      step(rr, ff, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 4, meaning the data word width in bits, matching the shared FIFO width.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning the maximum number of consecutive writes per grant (legal range 1..16).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  4  per-requester write request; bit i belongs to requester i.
REQ-006 wr_data  in  4*MEMORY_WIDTH  packed requester data; requester i occupies bits [i*MEMORY_WIDTH +: MEMORY_WIDTH].
REQ-007 FULL  in  1  full flag from the downstream synchronous FIFO.
REQ-008 gnt  out  4  registered one-hot grant; all zero when no requester is granted.
REQ-009 ack  out  4  one-hot, combinational; bit i high means requester i's word is written this cycle.
REQ-010 w_en  out  1  FIFO write enable.
REQ-011 WR  out  MEMORY_WIDTH  FIFO write data.

Function
REQ-012 SHALL implement a two-state FSM with states IDLE and BURST.
REQ-013 IDLE: gnt=0 and w_en=0; if any req bit is high, SHALL register a one-hot gnt and move to BURST.
REQ-014 The grant winner in IDLE SHALL be the first set req bit searching upward (modulo 4) from last+1, where last is the index of the previous grant.
REQ-015 BURST, write condition: w_en = req[g] & !FULL, where g is the granted index.
REQ-016 BURST, data path: WR = wr_data slice g and ack[g] = w_en, with all other ack bits 0.
REQ-017 Latency SHALL be 1 cycle: a req seen high in IDLE at edge N yields gnt at N+1, and the first write occurs in the cycle after N+1 if FULL is low.
REQ-018 BURST counter: a 4-bit cnt SHALL start at 0 on entry to BURST and increment on every accepted write (w_en=1).
REQ-019 BURST exit SHALL return to IDLE and clear gnt at the next edge when either condition holds:
  - req[g]=0, or
  - an accepted write occurs with cnt=BURST_LEN-1.
REQ-020 On every BURST exit, last SHALL load g.
REQ-021 When FULL=1 in BURST: w_en=0, ack=0, cnt holds, and the state stays BURST (no grant loss while stalled).
REQ-022 When req[g] drops while FULL=1, exit per REQ-019 SHALL still occur, with no write.
REQ-023 Every BURST exit SHALL pass through at least one IDLE cycle, so no requester can be granted twice without re-arbitration.
REQ-024 Requests from non-granted requesters SHALL be ignored during BURST and SHALL produce ack=0.
REQ-025 When gnt=0, WR SHALL be all zeros.
REQ-026 w_en SHALL never be high while FULL is high.

Reset
REQ-027 While rst is high: state=IDLE, gnt=0, cnt=0, and last=3, so requester 0 has highest priority after reset.
REQ-028 With rst high, the outputs SHALL be w_en=0, ack=0 and WR=0 regardless of req or FULL.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately with no write in that cycle.
REQ-030 The first arbitration after reset release SHALL occur at the first rising edge with rst low.

Structure
REQ-031 Shared package SHALL hold:
  - the FSM state encoding (IDLE=0, BURST=1),
  - the requester count constant (4),
  - the default BURST_LEN.
REQ-032 The round-robin search SHALL be a sub-module named rr_pick, with ports req[3:0], last[1:0], valid and idx[1:0].
REQ-033 The state, gnt, last and cnt registers SHALL use the team's asynchronous-reset enable flop, d_ff_async_en.

Verification
REQ-034 Reset then req=4'b0001, FULL=0, BURST_LEN=4 -> gnt=0001 next cycle, then 4 writes with ack=0001, then IDLE with gnt=0.
REQ-035 req=4'b1111 held, FULL=0, BURST_LEN=2 -> grant order 0,1,2,3,0, each grant doing 2 writes followed by 1 IDLE cycle.
REQ-036 Requester 2 granted, FULL=1 for 3 cycles mid-burst -> w_en=0 for those cycles, cnt holds, gnt stays 0100, and the burst resumes with the remaining writes.
REQ-037 Requester 1 granted, req[1] dropped after 1 write -> IDLE next cycle, last=1, and a pending req[0] is granted after req[3]/req[2] per the search order.
REQ-038 rst pulsed mid-burst with req=4'b1000 -> gnt=0 and w_en=0 during reset; after release the first grant goes to requester 3 only if requesters 0..2 are not requesting.
REQ-039 Random req/FULL for 10k cycles -> ack one-hot or zero, w_en never high with FULL high, and no requester gets more than BURST_LEN consecutive writes per grant.
